// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared 7-segment display definitions for the display designs.
//   Segment vectors are ordered gfedcba (bit 0 = segment a), active-high.
//
//   Contents:
//     seg7_t       7-bit segment vector type
//     hex_t        4-bit hex digit type
//     SEG_0..SEG_F glyphs for the hex digits 0-F
//     SEG_BLANK    all segments off
// -----------------------------------------------------------------------------
package seg7_pkg;

   typedef logic [6:0] seg7_t;
   typedef logic [3:0] hex_t;

   localparam seg7_t SEG_0     = 7'h3F;
   localparam seg7_t SEG_1     = 7'h06;
   localparam seg7_t SEG_2     = 7'h5B;
   localparam seg7_t SEG_3     = 7'h4F;
   localparam seg7_t SEG_4     = 7'h66;
   localparam seg7_t SEG_5     = 7'h6D;
   localparam seg7_t SEG_6     = 7'h7D;
   localparam seg7_t SEG_7     = 7'h07;
   localparam seg7_t SEG_8     = 7'h7F;
   localparam seg7_t SEG_9     = 7'h6F;
   localparam seg7_t SEG_A     = 7'h77;
   localparam seg7_t SEG_B     = 7'h7C;
   localparam seg7_t SEG_C     = 7'h39;
   localparam seg7_t SEG_D     = 7'h5E;
   localparam seg7_t SEG_E     = 7'h79;
   localparam seg7_t SEG_F     = 7'h71;
   localparam seg7_t SEG_BLANK = 7'h00;

endpackage : seg7_pkg

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
//   Purely combinational hex digit to 7-segment glyph decoder.
//
//   Ports:
//     i_hex  in   4  hex digit 0-F
//     o_seg  out  7  segments gfedcba, active-high, bit 0 = a
// -----------------------------------------------------------------------------
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      // NOTE: o_seg gets a value on every path (default arm below); a path
      // that leaves a combinational output unassigned infers a latch.
      o_seg = SEG_BLANK;
      case (i_hex)
         4'h0:    o_seg = SEG_0;
         4'h1:    o_seg = SEG_1;
         4'h2:    o_seg = SEG_2;
         4'h3:    o_seg = SEG_3;
         4'h4:    o_seg = SEG_4;
         4'h5:    o_seg = SEG_5;
         4'h6:    o_seg = SEG_6;
         4'h7:    o_seg = SEG_7;
         4'h8:    o_seg = SEG_8;
         4'h9:    o_seg = SEG_9;
         4'hA:    o_seg = SEG_A;
         4'hB:    o_seg = SEG_B;
         4'hC:    o_seg = SEG_C;
         4'hD:    o_seg = SEG_D;
         4'hE:    o_seg = SEG_E;
         4'hF:    o_seg = SEG_F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule : seg7_hex_decoder

// File: rtl/tt_um_seg_counter.sv
// -----------------------------------------------------------------------------
// tt_um_seg_counter
//   Tiny Tapeout user design: a single hex digit on the 7-segment display that
//   counts up or down once every CLK_DIV clocks, wraps at MAX_DIGIT, and can be
//   loaded from ui_in[7:4] on a rising edge of the (asynchronous) load strobe.
//   The decimal point blinks by toggling on every count tick.
//
//   Parameters:
//     CLK_DIV    clk cycles per count tick (>= 2)
//     MAX_DIGIT  highest count value (1..15); wrap point
//
//   Ports:
//     clk      in   1  system clock
//     rst_n    in   1  asynchronous active-low reset
//     ena      in   1  design selected; low freezes everything but the sync
//     ui_in    in   8  [0] load strobe (async), [1] down, [2] pause,
//                      [7:4] load value
//     uo_out   out  8  [6:0] segments gfedcba, [7] decimal point (registered)
//     uio_in   in   8  unused
//     uio_out  out  8  [3:0] current count, [7:4] zero
//     uio_oe   out  8  constant 8'h0F
// -----------------------------------------------------------------------------
module tt_um_seg_counter
   import seg7_pkg::*;
#(
   parameter int CLK_DIV   = 10_000_000,
   parameter int MAX_DIGIT = 15
)(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam int              PRESC_W    = $clog2(CLK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
   localparam hex_t            MAX_VAL    = 4'(MAX_DIGIT);

   // Load strobe synchronizer and rising-edge detector.
   logic               r_load_sync1;
   logic               r_load_sync2;
   logic               r_load_prev;

   logic [PRESC_W-1:0] r_presc;
   hex_t               r_count;
   logic               r_dp;
   logic [7:0]         r_uo_out;

   logic               w_load;
   logic               w_run;
   logic               w_tick;
   hex_t               w_load_val;
   hex_t               w_count_next;
   logic [6:0]         w_seg;
   logic               w_unused;

   // -------------------------------------------------------------------------
   // Synchronizer: runs regardless of ena so the strobe history stays current.
   // A strobe edge sampled at edge N reaches r_load_sync2 at N+1, so the
   // one-cycle load pulse is consumed at edge N+2.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the
      // synchronizer chain into a single stage.
      if (!rst_n) begin
         r_load_sync1 <= 1'b0;
         r_load_sync2 <= 1'b0;
         r_load_prev  <= 1'b0;
      end else begin
         r_load_sync1 <= ui_in[0];
         r_load_sync2 <= r_load_sync1;
         r_load_prev  <= r_load_sync2;
      end
   end

   // A load pulse arriving while the design is deselected is dropped.
   assign w_load = ena & r_load_sync2 & ~r_load_prev;

   // Pause and direction are static controls, used without synchronization.
   assign w_run  = ena & ~ui_in[2];
   assign w_tick = w_run & (r_presc == PRESC_LAST);

   assign w_load_val = (ui_in[7:4] > MAX_VAL) ? MAX_VAL : ui_in[7:4];

   always_comb begin
      w_count_next = r_count;
      if (ui_in[1]) begin
         w_count_next = (r_count == 4'd0) ? MAX_VAL : r_count - 4'd1;
      end else begin
         w_count_next = (r_count == MAX_VAL) ? 4'd0 : r_count + 4'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Prescaler, counter and blink. A load restarts the count period and takes
   // priority over a coincident tick, which is then lost (dp does not toggle).
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_count <= 4'd0;
         r_dp    <= 1'b0;
      end else if (w_load) begin
         r_presc <= '0;
         r_count <= w_load_val;
      end else if (w_tick) begin
         r_presc <= '0;
         r_count <= w_count_next;
         r_dp    <= ~r_dp;
      end else if (w_run) begin
         r_presc <= r_presc + 1'b1;
      end
   end

   seg7_hex_decoder u_decoder (
      .i_hex (r_count),
      .o_seg (w_seg)
   );

   // Display register: one cycle behind the count/dp registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uo_out <= {1'b0, SEG_0};
      end else if (ena) begin
         r_uo_out <= {r_dp, w_seg};
      end
   end

   assign uo_out  = r_uo_out;
   assign uio_out = {4'h0, r_count};
   assign uio_oe  = 8'h0F;

   // Inputs with no function in this design.
   assign w_unused = ^{uio_in, ui_in[3]};

endmodule : tt_um_seg_counter

// File: tb/tb_tt_um_seg_counter.sv
// -----------------------------------------------------------------------------
// tb_tt_um_seg_counter
//   Two instances share stimulus: one wraps at 15, the other at 9. A
//   behavioural model tracks each one from the load/tick rules and every
//   clock the outputs of both are compared against it.
// -----------------------------------------------------------------------------
module tb_tt_um_seg_counter;

   localparam int DIV = 4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_a, uio_out_a, uio_oe_a;
   logic [7:0] uo_b, uio_out_b, uio_oe_b;

   tt_um_seg_counter #(.CLK_DIV(DIV), .MAX_DIGIT(15)) u_dut_a (
      .ui_in   (ui_in),
      .uo_out  (uo_a),
      .uio_in  (uio_in),
      .uio_out (uio_out_a),
      .uio_oe  (uio_oe_a),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   tt_um_seg_counter #(.CLK_DIV(DIV), .MAX_DIGIT(9)) u_dut_b (
      .ui_in   (ui_in),
      .uo_out  (uo_b),
      .uio_in  (uio_in),
      .uio_out (uio_out_b),
      .uio_oe  (uio_oe_b),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
        12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
         default: return 7'h00;
      endcase
   endfunction

   int         m_max [2] = '{15, 9};
   int         m_count [2];
   int         m_phase [2];   // run cycles elapsed in the current period
   bit         m_dp [2];
   logic [7:0] m_uo [2];
   bit         m_hist [$];    // strobe samples of the last three edges, oldest first

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_count[i] = 0;
         m_phase[i] = 0;
         m_dp[i]    = 1'b0;
         m_uo[i]    = 8'h3F;
      end
      m_hist = '{1'b0, 1'b0, 1'b0};
   endtask

   // Called once per rising edge with the inputs that edge sampled.
   task automatic model_edge();
      bit load_pulse;
      int lv;
      // A strobe rise first sampled two edges ago is acted on now.
      load_pulse = m_hist[1] && !m_hist[0];
      lv = int'(ui_in[7:4]);
      for (int i = 0; i < 2; i++) begin
         if (ena) begin
            m_uo[i] = {m_dp[i], seg_of(m_count[i])};
            if (load_pulse) begin
               m_count[i] = (lv > m_max[i]) ? m_max[i] : lv;
               m_phase[i] = 0;
            end else if (!ui_in[2]) begin
               m_phase[i]++;
               if (m_phase[i] == DIV) begin
                  m_phase[i] = 0;
                  m_dp[i]    = !m_dp[i];
                  if (ui_in[1]) m_count[i] = (m_count[i] == 0) ? m_max[i] : m_count[i] - 1;
                  else          m_count[i] = (m_count[i] + 1) % (m_max[i] + 1);
               end
            end
         end
      end
      void'(m_hist.pop_front());
      m_hist.push_back(ui_in[0]);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".uo_a"},   uo_a,      m_uo[0]);
      check({tag, ".cnt_a"},  uio_out_a, 8'(m_count[0]));
      check({tag, ".oe_a"},   uio_oe_a,  8'h0F);
      check({tag, ".uo_b"},   uo_b,      m_uo[1]);
      check({tag, ".cnt_b"},  uio_out_b, 8'(m_count[1]));
      check({tag, ".oe_b"},   uio_oe_b,  8'h0F);
   endtask

   // Inputs change 1 time unit after an edge; outputs are sampled there too.
   task automatic step(input logic [7:0] ui, input logic en, input string tag);
      ui_in = ui;
      ena   = en;
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [7:0] ui;
      logic       en;
      n_cmp  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset("por");
      check("reset_uo", uo_a, 8'h3F);
      check("reset_uio", uio_out_a, 8'h00);

      // First tick after four clocks, displayed one clock later.
      repeat (4) step(8'h00, 1'b1, "run");
      check("tick1_cnt", uio_out_a, 8'h01);
      step(8'h00, 1'b1, "run");
      check("tick1_uo", uo_a, 8'h86);
      repeat (59) step(8'h00, 1'b1, "run");
      check("wrap15_cnt", uio_out_a, 8'h00);
      check("wrap9_cnt", uio_out_b, 8'h06);

      // Load 5: strobe seen at edge N, which lands on a tick edge (N+2).
      step(8'h50, 1'b1, "ld");
      step(8'h51, 1'b1, "ld");        // edge N
      step(8'h51, 1'b1, "ld");        // N+1
      step(8'h50, 1'b1, "ld");        // N+2
      check("load5_cnt", uio_out_a, 8'h05);
      step(8'h50, 1'b1, "ld");        // N+3
      check("load5_uo", uo_a, 8'h6D);
      step(8'h50, 1'b1, "ld");
      step(8'h50, 1'b1, "ld");        // N+5
      check("load5_hold", uio_out_a, 8'h05);
      step(8'h50, 1'b1, "ld");        // N+6: first tick after load
      check("load5_tick", uio_out_a, 8'h06);

      // Load 0 then count down: wraps to MAX_DIGIT.
      step(8'h00, 1'b1, "dn");
      step(8'h01, 1'b1, "dn");
      step(8'h01, 1'b1, "dn");
      step(8'h02, 1'b1, "dn");
      check("load0_cnt", uio_out_a, 8'h00);
      repeat (4) step(8'h02, 1'b1, "dn");
      check("down_wrap_a", uio_out_a, 8'h0F);
      check("down_wrap_b", uio_out_b, 8'h09);
      step(8'h02, 1'b1, "dn");
      check("down_seg_a", {1'b0, uo_a[6:0]}, 8'h71);

      // Pause, then deselect with a strobe that must be ignored.
      repeat (2) step(8'h00, 1'b1, "mid");
      repeat (20) step(8'h04, 1'b1, "pause");
      repeat (6) step(8'h00, 1'b1, "resume");
      repeat (4) step(8'h31, 1'b0, "ena0");
      repeat (16) step(8'h30, 1'b0, "ena0");
      repeat (6) step(8'h00, 1'b1, "resume");

      // Oversized load on a tick edge: clamps on the 9-wrap instance.
      do_reset("rst2");
      step(8'hC0, 1'b1, "clamp");     // edge 1
      step(8'hC1, 1'b1, "clamp");     // edge 2: strobe sampled
      step(8'hC0, 1'b1, "clamp");     // edge 3
      step(8'hC0, 1'b1, "clamp");     // edge 4: load, would-be tick
      check("clamp_a", uio_out_a, 8'h0C);
      check("clamp_b", uio_out_b, 8'h09);
      repeat (4) step(8'h00, 1'b1, "clamp");
      check("clamp_tick_a", uio_out_a, 8'h0D);
      check("clamp_tick_b", uio_out_b, 8'h00);

      // Randomized traffic with occasional asynchronous resets.
      ui = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         ui[7:4] = 4'($urandom);
         ui[3]   = 1'($urandom);
         if ($urandom_range(0, 3) == 0)  ui[0] = ~ui[0];
         if ($urandom_range(0, 31) == 0) ui[1] = ~ui[1];
         ui[2] = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 9) != 0);
         uio_in = 8'($urandom);
         step(ui, en, "rnd");
         if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_tt_um_seg_counter
